// File: rtl/apb3_slot_mux.sv
// APB3 one-to-many slot multiplexer: decodes a 4-bit address field into a slave select,
// routes the selected slave's response back, and aborts transfers whose slave stalls too long.
module apb3_slot_mux #(
    parameter int          APB_DWIDTH     = 32,
    parameter int          NUM_SLOTS      = 16,
    parameter logic [15:0] SLOT_ENABLE    = 16'hFFFF,
    parameter int          SLOT_LSB       = 24,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                            PCLK,
    input  logic                            PRESETN,
    input  logic [31:0]                     PADDR,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic                            PWRITE,
    input  logic [APB_DWIDTH-1:0]           PWDATA,
    output logic [APB_DWIDTH-1:0]           PRDATA,
    output logic                            PREADY,
    output logic                            PSLVERR,
    output logic [NUM_SLOTS-1:0]            PSELS,
    output logic [31:0]                     PADDRS,
    output logic                            PENABLES,
    output logic                            PWRITES,
    output logic [APB_DWIDTH-1:0]           PWDATAS,
    input  logic [NUM_SLOTS*APB_DWIDTH-1:0] PRDATAS,
    input  logic [NUM_SLOTS-1:0]            PREADYS,
    input  logic [NUM_SLOTS-1:0]            PSLVERRS,
    output logic                            TIMEOUT_EVT,
    output logic [15:0]                     ERR_COUNT
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ABORT  = 2'd3;

    localparam logic [4:0]  NUM_SLOTS_W  = 5'(NUM_SLOTS);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            slot_q;
    logic [3:0]            slot_field;
    logic [3:0]            dec_slot;
    logic [15:0]           wcnt;
    logic [15:0]           err_count;
    logic                  timeout_evt;
    logic                  setup_phase;
    logic                  q_valid;
    logic                  sel_ready;
    logic                  sel_err;
    logic [APB_DWIDTH-1:0] sel_data;

    function automatic logic slot_ok(input logic [3:0] s);
        return ({1'b0, s} < NUM_SLOTS_W) && SLOT_ENABLE[s];
    endfunction

    assign slot_field  = PADDR[SLOT_LSB +: 4];
    assign setup_phase = PSEL & ~PENABLE;
    assign q_valid     = slot_ok(slot_q);
    assign dec_slot    = (state == ACCESS) ? slot_q : slot_field;

    assign PADDRS      = PADDR;
    assign PWRITES     = PWRITE;
    assign PWDATAS     = PWDATA;
    assign PENABLES    = PENABLE & (|PSELS);
    assign TIMEOUT_EVT = timeout_evt;
    assign ERR_COUNT   = err_count;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == 4'(i)) begin
                sel_ready = PREADYS[i];
                sel_err   = PSLVERRS[i];
                sel_data  = PRDATAS[i*APB_DWIDTH +: APB_DWIDTH];
            end
        end
    end

    // Selects are gated by reset so a master already driving PSEL cannot reach a slave while in reset
    always_comb begin
        PSELS = '0;
        if (PRESETN && PSEL && (state != ABORT) && slot_ok(dec_slot)) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (dec_slot == 4'(i)) PSELS[i] = 1'b1;
            end
        end
    end

    always_comb begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        case (state)
            ACCESS: begin
                if (q_valid) begin
                    PREADY  = sel_ready;
                    PSLVERR = sel_err & sel_ready;
                    PRDATA  = sel_data;
                end else begin
                    PSLVERR = 1'b1;
                end
            end
            ABORT:   PSLVERR = 1'b1;
            default: ;
        endcase
    end

    // A valid ACCESS persists until the master leaves it; an unmapped slot answers once and drops out
    always_comb begin
        state_nxt = state;
        if (state == ABORT) begin
            state_nxt = IDLE;
        end else if (setup_phase) begin
            state_nxt = SETUP;
        end else begin
            case (state)
                SETUP:  state_nxt = (PSEL && PENABLE) ? ACCESS : IDLE;
                ACCESS: begin
                    if (!PSEL || !q_valid)
                        state_nxt = IDLE;
                    else if (!sel_ready && (wcnt == TIMEOUT_LAST))
                        state_nxt = ABORT;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= IDLE;
            slot_q      <= '0;
            wcnt        <= '0;
            timeout_evt <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            timeout_evt <= (state_nxt == ABORT);
            if (setup_phase && (state != ABORT)) slot_q <= slot_field;
            if ((state == ACCESS) && (state_nxt == ACCESS)) begin
                if (!PREADY) wcnt <= wcnt + 16'd1;
            end else begin
                wcnt <= '0;
            end
            if (PREADY && PSLVERR && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: doc/apb3_slot_mux.md
APB3_SLOT_MUX -- requirements
Module: apb3_slot_mux

Interface
REQ-001 SHALL have parameter APB_DWIDTH, default 32, meaning data width; legal values 8, 16, 32.
REQ-002 SHALL have parameter NUM_SLOTS, default 16, meaning slave slot count; legal range 1..16.
REQ-003 SHALL have parameter SLOT_ENABLE, default 16'hFFFF, meaning per-slot enable mask; bit i enables slot i.
REQ-004 SHALL have parameter SLOT_LSB, default 24, meaning LSB of the 4-bit slot field PADDR[SLOT_LSB+3:SLOT_LSB].
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning wait cycles allowed before abort; legal range 2..65535.
REQ-006 SHALL have port PCLK, input, width 1: the single clock; all state is updated on the rising edge.
REQ-007 SHALL have port PRESETN, input, width 1: asynchronous, active-low reset.
REQ-008 SHALL have master-side inputs PADDR [31:0], PSEL, PENABLE, PWRITE, and PWDATA [APB_DWIDTH-1:0].
REQ-009 SHALL have master-side outputs PRDATA [APB_DWIDTH-1:0], PREADY, and PSLVERR.
REQ-010 SHALL have slave-side outputs PSELS [NUM_SLOTS-1:0], PADDRS [31:0], PENABLES, PWRITES, and PWDATAS [APB_DWIDTH-1:0].
REQ-011 SHALL have slave-side inputs PRDATAS [NUM_SLOTS*APB_DWIDTH-1:0] (slot i at bits [i*APB_DWIDTH +: APB_DWIDTH]), PREADYS [NUM_SLOTS-1:0], and PSLVERRS [NUM_SLOTS-1:0].
REQ-012 SHALL have status outputs TIMEOUT_EVT (1 bit, one-cycle pulse) and ERR_COUNT [15:0] (count of error completions).

Function
REQ-013 SHALL implement states IDLE, SETUP, ACCESS, and ABORT.
REQ-014 Setup phase (PSEL=1, PENABLE=0) SHALL latch the slot field into slot_q and enter SETUP from any state except ABORT.
REQ-015 SETUP SHALL go to ACCESS on the next cycle if PSEL=1 and PENABLE=1; otherwise it SHALL go to IDLE.
REQ-016 A slot SHALL be valid if slot_q < NUM_SLOTS and SLOT_ENABLE[slot_q]=1.
REQ-017 PSELS[i] SHALL be PSEL & (decoded slot == i) & valid, where decoded slot is the combinational field in setup and slot_q in ACCESS; PSELS SHALL be all 0 in ABORT.
REQ-018 PADDRS, PWRITES, and PWDATAS SHALL be combinational pass-throughs of PADDR, PWRITE, and PWDATA.
REQ-019 PENABLES SHALL equal PENABLE & |PSELS.
REQ-020 In ACCESS with a valid slot: PREADY = PREADYS[slot_q]; PSLVERR = PSLVERRS[slot_q] & PREADY; PRDATA = the selected slot's PRDATAS.
REQ-021 In ACCESS with an invalid slot: PREADY=1, PSLVERR=1, PRDATA=0 in the first ACCESS cycle; no slave is selected.
REQ-022 wait counter wcnt (16 bit) SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-023 When wcnt == TIMEOUT_CYCLES-1 and PREADYS[slot_q]=0, the next state SHALL be ABORT.
REQ-024 ABORT SHALL last exactly one cycle with PREADY=1, PSLVERR=1, PRDATA=0, PSELS=0, and PENABLES=0, then go to IDLE.
REQ-025 TIMEOUT_EVT SHALL be registered and high for exactly the one cycle coinciding with ABORT.
REQ-026 A slave PREADY arriving in the same cycle wcnt reaches TIMEOUT_CYCLES-1 SHALL complete normally, with no ABORT.
REQ-027 ERR_COUNT SHALL increment on every cycle with PREADY=1 and PSLVERR=1, and SHALL saturate at 16'hFFFF.
REQ-028 PREADY, PSLVERR, and PRDATA outside ACCESS/ABORT SHALL be 1, 0, and 0 respectively.
REQ-029 A master deasserting PSEL mid-ACCESS SHALL return the FSM to IDLE next cycle and clear wcnt.

Reset
REQ-030 On PRESETN=0 the block SHALL asynchronously set state=IDLE, slot_q=0, wcnt=0, TIMEOUT_EVT=0, and ERR_COUNT=0.
REQ-031 During reset, PSELS=0, PENABLES=0, PREADY=1, PSLVERR=0, and PRDATA=0 SHALL hold.
REQ-032 Reset asserted mid-ACCESS SHALL abandon the transfer with no ABORT and no ERR_COUNT increment.

Verification
REQ-033 Read slot 3, PADDR=32'h0300_0010, PREADYS[3]=1, PRDATAS slot3=32'hA5A5_0001 -> PSELS=16'h0008 in setup/access; PRDATA=32'hA5A5_0001; PREADY=1 in the first ACCESS cycle.
REQ-034 SLOT_ENABLE=16'hFFF7, access slot 3 -> PSELS=0; PREADY=1 and PSLVERR=1 in the first ACCESS cycle; ERR_COUNT 0->1.
REQ-035 TIMEOUT_CYCLES=4, slot 1 PREADYS held 0 -> PREADY=0 for ACCESS cycles 0..3; cycle 4 has PREADY=1, PSLVERR=1, TIMEOUT_EVT=1, PSELS=0; then IDLE.
REQ-036 TIMEOUT_CYCLES=4, PREADYS[1] rises in ACCESS cycle 3 -> normal completion, PSLVERR=0, TIMEOUT_EVT stays 0.
REQ-037 PRESETN pulsed low during ACCESS cycle 2 of a waiting transfer -> all outputs take reset values immediately; ERR_COUNT=0; no TIMEOUT_EVT.
REQ-038 Force 65536 consecutive error completions -> ERR_COUNT holds at 16'hFFFF.
